// File: rtl/input_conditioner.sv
// Synchronises and debounces the start/clear push-buttons into single-cycle pulses, and hands
// start requests to the sequencer with a one-deep queue and an acknowledge timeout.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       clear_btn,
  input  logic       running,
  output logic       start,
  output logic       clear,
  output logic       pending,
  output logic       overrun,
  output logic       ack_timeout,
  output logic [7:0] press_count
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TmrW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(ACK_TIMEOUT);
  localparam int unsigned ChStart = 0;
  localparam int unsigned ChClear = 1;

  typedef enum logic [1:0] {StIdle, StWaitRun, StBusy} state_e;

  logic [1:0]           btn_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           level_q, level_d, level_prev_q;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0]           evt;
  logic                 start_evt, clear_evt, issue;

  state_e          state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            start_q, start_d;
  logic            clear_q, clear_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            ack_q, ack_d;
  logic [7:0]      count_q, count_d;

  assign btn_raw = {clear_btn, start_btn};

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign evt       = level_q & ~level_prev_q;
  assign start_evt = evt[ChStart];
  assign clear_evt = evt[ChClear];

  // A queued request takes precedence over a fresh one; the fresh one then becomes queued.
  assign issue = (state_q == StIdle) && !running && (start_evt || pending_q);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    start_d   = 1'b0;
    clear_d   = clear_evt;
    pending_d = pending_q;
    overrun_d = overrun_q;
    ack_d     = ack_q;
    count_d   = count_q;

    if (clear_evt) begin
      state_d   = StIdle;
      timer_d   = '0;
      pending_d = 1'b0;
      overrun_d = 1'b0;
      ack_d     = 1'b0;
      count_d   = '0;
    end else begin
      if (start_evt && (count_q != 8'hFF)) begin
        count_d = count_q + 8'd1;
      end

      if (issue) begin
        pending_d = pending_q && start_evt;
      end else if (start_evt) begin
        if (pending_q) begin
          overrun_d = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end

      case (state_q)
        StIdle: begin
          if (running) begin
            state_d = StBusy;
          end else if (issue) begin
            start_d = 1'b1;
            state_d = StWaitRun;
            timer_d = '0;
          end
        end
        StWaitRun: begin
          if (running) begin
            state_d = StBusy;
          end else if (timer_q == TmrMax) begin
            ack_d   = 1'b1;
            state_d = StIdle;
          end else begin
            timer_d = timer_q + TmrW'(1);
          end
        end
        StBusy: begin
          if (!running) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      ack_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      start_q   <= start_d;
      clear_q   <= clear_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      ack_q     <= ack_d;
      count_q   <= count_d;
    end
  end

  assign start       = start_q;
  assign clear       = clear_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;
  assign ack_timeout = ack_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random button/running activity, all
// compared against a sample-window debounce model and a request-level handshake model.
module tb_input_conditioner;

  localparam int Deb = 16;
  localparam int Tmo = 8;

  logic       clk;
  logic       rst_n, start_btn, clear_btn, running;
  logic       start, clear, pending, overrun, ack_timeout;
  logic [7:0] press_count;
  logic [12:0] dut_vec;
  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(Deb),
    .ACK_TIMEOUT    (Tmo)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start_btn  (start_btn),
    .clear_btn  (clear_btn),
    .running    (running),
    .start      (start),
    .clear      (clear),
    .pending    (pending),
    .overrun    (overrun),
    .ack_timeout(ack_timeout),
    .press_count(press_count)
  );

  assign dut_vec = {start, clear, pending, overrun, ack_timeout, press_count};

  // Reference model: a level flips once the last Deb synchronised samples since the previous
  // flip all disagree with it; requests follow the handshake rules directly.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_lvl [2];
  bit m_prev [2];
  bit m_hist [2][Deb];
  int m_since [2];
  int m_state;  // 0 idle, 1 waiting for running, 2 busy
  int m_cyc, m_issue_cyc, m_cnt;
  bit m_start, m_clear, m_pend, m_ovr, m_ack;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_prev[i] = 0; m_since[i] = 0;
      for (int j = 0; j < Deb; j++) m_hist[i][j] = 0;
    end
    m_state = 0; m_cyc = 0; m_issue_cyc = 0; m_cnt = 0;
    m_start = 0; m_clear = 0; m_pend = 0; m_ovr = 0; m_ack = 0;
  endtask

  task automatic m_step();
    bit raw [2];
    bit e [2];
    bit samp, allmis, issue, run;
    raw[0] = start_btn; raw[1] = clear_btn; run = running;
    m_cyc++;
    for (int i = 0; i < 2; i++) begin
      samp = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = raw[i];
      for (int j = Deb - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
      m_hist[i][0] = samp;
      if (m_since[i] < Deb) m_since[i]++;
      e[i] = m_lvl[i] && !m_prev[i];
      m_prev[i] = m_lvl[i];
      allmis = (m_since[i] >= Deb);
      for (int j = 0; j < Deb; j++) if (m_hist[i][j] == m_lvl[i]) allmis = 0;
      if (allmis) begin m_lvl[i] = samp; m_since[i] = 0; end
    end
    m_start = 0;
    m_clear = e[1];
    if (e[1]) begin
      m_state = 0; m_pend = 0; m_ovr = 0; m_ack = 0; m_cnt = 0;
    end else begin
      if (e[0] && m_cnt < 255) m_cnt++;
      issue = (m_state == 0) && !run && (e[0] || m_pend);
      if (issue) begin
        m_start = 1;
        m_pend  = m_pend && e[0];
      end else if (e[0]) begin
        if (m_pend) m_ovr = 1; else m_pend = 1;
      end
      case (m_state)
        0: if (run) m_state = 2; else if (issue) begin m_state = 1; m_issue_cyc = m_cyc; end
        1: if (run) m_state = 2;
           else if (m_cyc - m_issue_cyc == Tmo + 1) begin m_ack = 1; m_state = 0; end
        2: if (!run) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  function automatic logic [12:0] model_vec();
    return {m_start, m_clear, m_pend, m_ovr, m_ack, 8'(m_cnt)};
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset(); else m_step();
    end
  end

  task automatic do_reset();
    rst_n = 0; start_btn = 0; clear_btn = 0; running = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; start_btn = 1; clear_btn = 1; running = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (dut_vec !== 13'h0) begin
      failures++; $display("FAIL reset_outputs got=%h want=%h", dut_vec, 13'h0);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++; $display("FAIL reset_model got=%h want=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_basic_start();
    do_reset();
    start_btn = 1;
    for (int e = 0; e < 32; e++) begin
      if (e == 20) running = 1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (start !== 1'(e == Deb + 2)) begin
        failures++; $display("FAIL basic_start_edge edge=%0d got=%b want=%b", e, start, e == Deb + 2);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL basic_model edge=%0d got=%h want=%h", e, dut_vec, model_vec());
      end
    end
    checks++;
    if (press_count !== 8'd1) begin
      failures++; $display("FAIL basic_count got=%0d want=1", press_count);
    end
    start_btn = 0; running = 0;
  endtask

  task automatic test_bounce();
    int pulses;
    do_reset();
    pulses = 0;
    for (int c = 0; c < 140; c++) begin
      start_btn = (c < 100) ? ((c / 10) % 2 == 0) : 1'b1;
      @(posedge clk); @(negedge clk);
      if (start === 1'b1) pulses++;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL bounce_model c=%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
    checks++;
    if (pulses != 1 || press_count !== 8'd1) begin
      failures++; $display("FAIL bounce_one_pulse got=%0d/%0d want=1/1", pulses, press_count);
    end
    pulses = 0;
    for (int c = 0; c < 95; c++) begin
      start_btn = (c >= 40 && c < 55);
      @(posedge clk); @(negedge clk);
      if (start === 1'b1) pulses++;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL glitch_model c=%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
    checks++;
    if (pulses != 0 || press_count !== 8'd1) begin
      failures++; $display("FAIL glitch_rejected got=%0d/%0d want=0/1", pulses, press_count);
    end
  endtask

  task automatic test_queue_overrun();
    int pulses;
    do_reset();
    running = 1;
    pulses = 0;
    for (int c = 0; c < 96; c++) begin
      start_btn = (c % 48) < 24;
      @(posedge clk); @(negedge clk);
      if (start === 1'b1) pulses++;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL queue_model c=%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
    checks++;
    if ({pulses != 0, pending, overrun, press_count} !== {1'b0, 1'b1, 1'b1, 8'd2}) begin
      failures++;
      $display("FAIL queue_flags got pulses=%0d pend=%b ovr=%b cnt=%0d want 0/1/1/2",
               pulses, pending, overrun, press_count);
    end
    running = 0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (start !== 1'b0 || pending !== 1'b1) begin
      failures++; $display("FAIL queue_edge1 got start=%b pend=%b want 0/1", start, pending);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (start !== 1'b1 || pending !== 1'b0) begin
      failures++; $display("FAIL queue_edge2 got start=%b pend=%b want 1/0", start, pending);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++; $display("FAIL queue_issue_model got=%h want=%h", dut_vec, model_vec());
    end
    running = 1;
    repeat (3) @(negedge clk);
    running = 0;
  endtask

  task automatic test_ack_timeout();
    int s_edge, a_edge, pulses;
    do_reset();
    s_edge = -1; a_edge = -1; pulses = 0;
    for (int c = 0; c < 60; c++) begin
      start_btn = (c < 24);
      @(posedge clk); @(negedge clk);
      if (start === 1'b1) begin pulses++; if (s_edge < 0) s_edge = c; end
      if (ack_timeout === 1'b1 && a_edge < 0) a_edge = c;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL ack_model c=%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
    checks++;
    if (s_edge != Deb + 2 || pulses != 1) begin
      failures++; $display("FAIL ack_start got edge=%0d n=%0d want %0d/1", s_edge, pulses, Deb + 2);
    end
    checks++;
    if (a_edge - s_edge != Tmo + 1) begin
      failures++; $display("FAIL ack_delay got=%0d want=%0d", a_edge - s_edge, Tmo + 1);
    end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      start_btn = (c < 24);
      @(posedge clk); @(negedge clk);
      if (start === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || press_count !== 8'd2) begin
      failures++; $display("FAIL ack_reissue got=%0d/%0d want=1/2", pulses, press_count);
    end
    start_btn = 0;
  endtask

  task automatic test_clear_priority();
    int sp, cp;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      start_btn = (c < 24);
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (ack_timeout !== 1'b1 || press_count !== 8'd1) begin
      failures++; $display("FAIL clear_setup got ack=%b cnt=%0d want 1/1", ack_timeout, press_count);
    end
    sp = 0; cp = 0;
    for (int c = 0; c < 60; c++) begin
      start_btn = (c < 24); clear_btn = (c < 24);
      @(posedge clk); @(negedge clk);
      if (start === 1'b1) sp++;
      if (clear === 1'b1) cp++;
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL clear_model c=%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
    checks++;
    if (sp != 0 || cp != 1) begin
      failures++; $display("FAIL clear_pulses got start=%0d clear=%0d want 0/1", sp, cp);
    end
    checks++;
    if ({pending, overrun, ack_timeout, press_count} !== 11'h0) begin
      failures++;
      $display("FAIL clear_flags got=%b%b%b cnt=%0d want 000/0", pending, overrun, ack_timeout,
               press_count);
    end
    start_btn = 0; clear_btn = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int p = 0; p < 260; p++) begin
      for (int c = 0; c < 40; c++) begin
        start_btn = (c < 20);
        running   = (c >= 25 && c < 32);
        @(posedge clk); @(negedge clk);
        checks++;
        if (dut_vec !== model_vec()) begin
          failures++; $display("FAIL sat_model p=%0d c=%0d got=%h want=%h", p, c, dut_vec,
                               model_vec());
        end
      end
    end
    checks++;
    if (press_count !== 8'd255) begin
      failures++; $display("FAIL sat_count got=%0d want=255", press_count);
    end
    start_btn = 0; running = 0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      start_btn = (c < 24);
      @(posedge clk); @(negedge clk);
    end
    start_btn = 1;
    repeat (10) @(negedge clk);
    checks++;
    if (press_count !== 8'd1 || ack_timeout !== 1'b1) begin
      failures++; $display("FAIL rst_setup got cnt=%0d ack=%b want 1/1", press_count, ack_timeout);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_vec !== 13'h0) begin
      failures++; $display("FAIL rst_async got=%h want=%h", dut_vec, 13'h0);
    end
    @(negedge clk);
    rst_n = 1;
    for (int e = 0; e < 24; e++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (start !== 1'(e == Deb + 2)) begin
        failures++; $display("FAIL rst_held_edge edge=%0d got=%b want=%b", e, start, e == Deb + 2);
      end
    end
    start_btn = 0;
    repeat (30) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (start === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL rst_released_btn got=%0d want=0", pulses);
    end
  endtask

  task automatic test_random();
    int sb_left, cb_left, rn_left;
    do_reset();
    sb_left = 0; cb_left = 0; rn_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (sb_left == 0) begin
        start_btn = ~start_btn; sb_left = $urandom_range(40, 1);
      end else sb_left--;
      if (cb_left == 0) begin
        clear_btn = clear_btn ? 1'b0 : ($urandom_range(7, 0) == 0);
        cb_left = $urandom_range(60, 5);
      end else cb_left--;
      if (rn_left == 0) begin
        running = ~running; rn_left = $urandom_range(15, 1);
      end else rn_left--;
      @(posedge clk); @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL random_model c=%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
    start_btn = 0; clear_btn = 0; running = 0;
  endtask

  initial begin
    rst_n = 0; start_btn = 0; clear_btn = 0; running = 0;
    test_reset();
    test_basic_start();
    test_bounce();
    test_queue_overrun();
    test_ack_timeout();
    test_clear_priority();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
